// File: rtl/coeff_ctrl_pkg.sv
// Shared types and constants for the biquad coefficient update controller:
// command codes, FSM states, slot map and reset coefficient values.
package coeff_ctrl_pkg;

  localparam int NUM_COEFF   = 10;
  localparam int COEFF_BYTES = 8;
  localparam int COEFF_W     = 64;

  typedef enum logic [7:0] {
    CMD_WRITE   = 8'h10,
    CMD_COMMIT  = 8'h20,
    CMD_DISCARD = 8'h30,
    CMD_CLR_ERR = 8'h40
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GET_IDX  = 2'd1,
    ST_GET_DATA = 2'd2,
    ST_DROP     = 2'd3
  } state_e;

  localparam int SLOT_HP_Y1 = 0;
  localparam int SLOT_HP_Y2 = 1;
  localparam int SLOT_HP_X0 = 2;
  localparam int SLOT_HP_X1 = 3;
  localparam int SLOT_HP_X2 = 4;
  localparam int SLOT_LP_Y1 = 5;
  localparam int SLOT_LP_Y2 = 6;
  localparam int SLOT_LP_X0 = 7;
  localparam int SLOT_LP_X1 = 8;
  localparam int SLOT_LP_X2 = 9;

  // 1.0 in Q2.62: feed-forward x0 taps pass the signal through after reset.
  localparam logic [COEFF_W-1:0] COEFF_ONE  = 64'h4000_0000_0000_0000;
  localparam logic [COEFF_W-1:0] COEFF_ZERO = 64'h0000_0000_0000_0000;

  function automatic logic [COEFF_W-1:0] reset_coeff(input int slot);
    if (slot == SLOT_HP_X0 || slot == SLOT_LP_X0) begin
      return COEFF_ONE;
    end else begin
      return COEFF_ZERO;
    end
  endfunction

endpackage

// File: rtl/coeff_bank.sv
// Shadow and active coefficient storage: per-slot shadow writes, atomic
// shadow-to-active commit and active-to-shadow discard.
module coeff_bank #(
  parameter int NUM_COEFF = coeff_ctrl_pkg::NUM_COEFF,
  parameter int IDX_W     = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic [63:0]                 wr_data,
  input  logic                        commit,
  input  logic                        discard,
  output logic [NUM_COEFF-1:0][63:0]  active
);
  import coeff_ctrl_pkg::*;

  logic [NUM_COEFF-1:0][63:0] shadow_r;
  logic [NUM_COEFF-1:0][63:0] active_r;

  // Active set only ever changes as a whole on commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_COEFF; i++) begin
        active_r[i] <= reset_coeff(i);
      end
    end else if (commit) begin
      active_r <= shadow_r;
    end else begin
      active_r <= active_r;
    end
  end

  // Shadow storage: discard restores the live set, otherwise single-slot writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_COEFF; i++) begin
        shadow_r[i] <= reset_coeff(i);
      end
    end else if (discard) begin
      shadow_r <= active_r;
    end else begin
      for (int i = 0; i < NUM_COEFF; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          shadow_r[i] <= wr_data;
        end else begin
          shadow_r[i] <= shadow_r[i];
        end
      end
    end
  end

  assign active = active_r;

endmodule

// File: rtl/coeff_update_ctrl.sv
// SPI-fed coefficient update controller: parses command frames into shadow
// writes and applies committed sets on the next audio sample boundary.
module coeff_update_ctrl #(
  parameter int NUM_COEFF   = coeff_ctrl_pkg::NUM_COEFF,
  parameter int COEFF_BYTES = coeff_ctrl_pkg::COEFF_BYTES
) (
  input  logic               clk_48,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [7:0]         rx_byte,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic               sample_tick,
  output logic signed [63:0] hp_y1_coeff,
  output logic signed [63:0] hp_y2_coeff,
  output logic signed [63:0] hp_x0_coeff,
  output logic signed [63:0] hp_x1_coeff,
  output logic signed [63:0] hp_x2_coeff,
  output logic signed [63:0] lp_y1_coeff,
  output logic signed [63:0] lp_y2_coeff,
  output logic signed [63:0] lp_x0_coeff,
  output logic signed [63:0] lp_x1_coeff,
  output logic signed [63:0] lp_x2_coeff,
  output logic               commit_pending,
  output logic               commit_done,
  output logic               err_flag
);
  import coeff_ctrl_pkg::*;

  localparam int IDX_W = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
  localparam int CNT_W = (COEFF_BYTES > 1) ? $clog2(COEFF_BYTES) : 1;

  state_e           state_r, state_next_s, cur_state_s;
  logic [IDX_W-1:0] idx_r, idx_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [63:0]      asm_r, asm_next_s;
  logic             err_r, err_next_s;
  logic             pending_r, pending_next_s, pending_set_s;
  logic             done_r, ready_r;
  logic             accept_s, wr_en_s, commit_s, discard_s;
  logic [NUM_COEFF-1:0][63:0] active_s;

  assign accept_s = rx_valid && ready_r;
  assign commit_s = sample_tick && pending_r;

  // Frame parser; a frame_start restarts parsing with the current byte as command.
  always_comb begin
    state_next_s  = state_r;
    idx_next_s    = idx_r;
    cnt_next_s    = cnt_r;
    asm_next_s    = asm_r;
    err_next_s    = err_r;
    pending_set_s = 1'b0;
    wr_en_s       = 1'b0;
    discard_s     = 1'b0;
    cur_state_s   = frame_start ? ST_IDLE : state_r;
    state_next_s  = cur_state_s;
    if (frame_start) begin
      cnt_next_s = CNT_W'(0);
      asm_next_s = 64'd0;
    end else begin
      cnt_next_s = cnt_r;
    end
    if (accept_s) begin
      case (cur_state_s)
        ST_IDLE: begin
          case (rx_byte)
            CMD_WRITE:   state_next_s  = ST_GET_IDX;
            CMD_COMMIT:  pending_set_s = 1'b1;
            CMD_DISCARD: discard_s     = 1'b1;
            CMD_CLR_ERR: err_next_s    = 1'b0;
            default: begin
              err_next_s   = 1'b1;
              state_next_s = ST_DROP;
            end
          endcase
        end
        ST_GET_IDX: begin
          if (int'(rx_byte) < NUM_COEFF) begin
            idx_next_s   = rx_byte[IDX_W-1:0];
            cnt_next_s   = CNT_W'(0);
            asm_next_s   = 64'd0;
            state_next_s = ST_GET_DATA;
          end else begin
            err_next_s   = 1'b1;
            state_next_s = ST_DROP;
          end
        end
        ST_GET_DATA: begin
          asm_next_s = {asm_r[55:0], rx_byte};
          if (cnt_r == CNT_W'(COEFF_BYTES - 1)) begin
            wr_en_s      = 1'b1;
            cnt_next_s   = CNT_W'(0);
            state_next_s = ST_IDLE;
          end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
          end
        end
        ST_DROP: state_next_s = ST_DROP;
        default: state_next_s = ST_IDLE;
      endcase
    end else begin
      state_next_s = cur_state_s;
    end
    if (pending_set_s) begin
      pending_next_s = 1'b1;
    end else if (commit_s) begin
      pending_next_s = 1'b0;
    end else begin
      pending_next_s = pending_r;
    end
  end

  // Control state and registered status outputs.
  always_ff @(posedge clk_48) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      idx_r     <= IDX_W'(0);
      cnt_r     <= CNT_W'(0);
      asm_r     <= 64'd0;
      err_r     <= 1'b0;
      pending_r <= 1'b0;
      done_r    <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      state_r   <= state_next_s;
      idx_r     <= idx_next_s;
      cnt_r     <= cnt_next_s;
      asm_r     <= asm_next_s;
      err_r     <= err_next_s;
      pending_r <= pending_next_s;
      done_r    <= commit_s;
      ready_r   <= !pending_next_s;
    end
  end

  coeff_bank #(
    .NUM_COEFF (NUM_COEFF),
    .IDX_W     (IDX_W)
  ) u_bank (
    .clk     (clk_48),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_idx  (idx_r),
    .wr_data (asm_next_s),
    .commit  (commit_s),
    .discard (discard_s),
    .active  (active_s)
  );

  assign rx_ready       = ready_r;
  assign commit_pending = pending_r;
  assign commit_done    = done_r;
  assign err_flag       = err_r;

  assign hp_y1_coeff = active_s[SLOT_HP_Y1];
  assign hp_y2_coeff = active_s[SLOT_HP_Y2];
  assign hp_x0_coeff = active_s[SLOT_HP_X0];
  assign hp_x1_coeff = active_s[SLOT_HP_X1];
  assign hp_x2_coeff = active_s[SLOT_HP_X2];
  assign lp_y1_coeff = active_s[SLOT_LP_Y1];
  assign lp_y2_coeff = active_s[SLOT_LP_Y2];
  assign lp_x0_coeff = active_s[SLOT_LP_X0];
  assign lp_x1_coeff = active_s[SLOT_LP_X1];
  assign lp_x2_coeff = active_s[SLOT_LP_X2];

endmodule

// File: tb/tb_coeff_update_ctrl.sv
// Scoreboard bench for coeff_update_ctrl: a shadow/active model queues the
// expected active set per commit; a monitor checks it on each commit_done.
module tb_coeff_update_ctrl;

  logic clk_48 = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic rx_valid = 1'b0;
  logic rx_ready;
  logic sample_tick = 1'b0;
  logic signed [63:0] hp_y1_coeff, hp_y2_coeff, hp_x0_coeff, hp_x1_coeff, hp_x2_coeff;
  logic signed [63:0] lp_y1_coeff, lp_y2_coeff, lp_x0_coeff, lp_x1_coeff, lp_x2_coeff;
  logic commit_pending, commit_done, err_flag;

  coeff_update_ctrl dut (
    .clk_48(clk_48), .reset(reset), .frame_start(frame_start),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .sample_tick(sample_tick),
    .hp_y1_coeff(hp_y1_coeff), .hp_y2_coeff(hp_y2_coeff), .hp_x0_coeff(hp_x0_coeff),
    .hp_x1_coeff(hp_x1_coeff), .hp_x2_coeff(hp_x2_coeff),
    .lp_y1_coeff(lp_y1_coeff), .lp_y2_coeff(lp_y2_coeff), .lp_x0_coeff(lp_x0_coeff),
    .lp_x1_coeff(lp_x1_coeff), .lp_x2_coeff(lp_x2_coeff),
    .commit_pending(commit_pending), .commit_done(commit_done), .err_flag(err_flag)
  );

  always #5 clk_48 = ~clk_48;

  logic [9:0][63:0] out_s;
  assign out_s[0] = hp_y1_coeff;
  assign out_s[1] = hp_y2_coeff;
  assign out_s[2] = hp_x0_coeff;
  assign out_s[3] = hp_x1_coeff;
  assign out_s[4] = hp_x2_coeff;
  assign out_s[5] = lp_y1_coeff;
  assign out_s[6] = lp_y2_coeff;
  assign out_s[7] = lp_x0_coeff;
  assign out_s[8] = lp_x1_coeff;
  assign out_s[9] = lp_x2_coeff;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [9:0][63:0] shadow_m, active_m, mon_exp;
  logic pend_m;
  logic [9:0][63:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rst_val(input int i);
    return (i == 2 || i == 7) ? 64'h4000_0000_0000_0000 : 64'h0;
  endfunction

  // Each commit_done must coincide with the queued expected active set.
  always @(negedge clk_48) begin
    if (!reset && commit_done === 1'b1) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("unexp_done", 64'(sb_q.size()), 64'd1);
      end else begin
        mon_exp = sb_q.pop_front();
        for (int i = 0; i < 10; i++) check($sformatf("commit_slot%0d", i), out_s[i], mon_exp[i]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_48);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      shadow_m[i] = rst_val(i);
      active_m[i] = rst_val(i);
    end
    pend_m = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic fs, input logic tk);
    int n;
    n = 0;
    while (rx_ready !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    if (n >= 100) check("rdy_timeout", 64'(rx_ready), 64'd1);
    frame_start = fs;
    sample_tick = tk;
    rx_valid = 1'b1;
    rx_byte = b;
    cyc();
    frame_start = 1'b0;
    sample_tick = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic write_coeff(input int idx, input logic [63:0] d);
    send(8'h10, 1'b1, 1'b0);
    send(8'(idx), 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) send(d[63-8*k -: 8], 1'b0, 1'b0);
    if (idx < 10) shadow_m[idx] = d;
  endtask

  task automatic commit();
    send(8'h20, 1'b1, 1'b0);
    pend_m = 1'b1;
    check("pending_set", 64'(commit_pending), 64'd1);
    check("ready_low", 64'(rx_ready), 64'd0);
  endtask

  task automatic do_tick();
    sample_tick = 1'b1;
    if (pend_m) begin
      active_m = shadow_m;
      sb_q.push_back(active_m);
      pend_m = 1'b0;
      exp_done++;
    end
    cyc();
    sample_tick = 1'b0;
    cyc();
    cyc();
    check("done_cnt", 64'(done_cnt), 64'(exp_done));
    check("pending_clr", 64'(commit_pending), 64'd0);
    check("ready_hi", 64'(rx_ready), 64'd1);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 10; i++) check($sformatf("%s_slot%0d", tag, i), out_s[i], active_m[i]);
  endtask

  initial begin
    logic [63:0] d;
    int s;
    do_reset();
    check_all("reset");
    check("rst_ready", 64'(rx_ready), 64'd1);
    check("rst_err", 64'(err_flag), 64'd0);
    check("rst_pend", 64'(commit_pending), 64'd0);
    check("rst_done", 64'(commit_done), 64'd0);

    // Full write, commit survives a bare frame_start, then applied on tick.
    write_coeff(3, 64'h0102030405060708);
    check_all("pre_commit");
    commit();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    check("pend_survives_fs", 64'(commit_pending), 64'd1);
    do_tick();
    check("hp_x1_after", hp_x1_coeff, 64'h0102030405060708);
    check("done_low_after", 64'(commit_done), 64'd0);

    // Partial write aborted by frame_start.
    send(8'h10, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send(8'hA0 + 8'(k), 1'b0, 1'b0);
    commit();
    check("abort_err", 64'(err_flag), 64'd0);
    do_tick();
    check("hp_y1_kept", hp_y1_coeff, 64'd0);

    // Unknown command drops the rest of the frame, including command-like bytes.
    send(8'h55, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) send(8'h10 + 8'(k * 8), 1'b0, 1'b0);
    check("bad_cmd_err", 64'(err_flag), 64'd1);
    check("drop_no_pend", 64'(commit_pending), 64'd0);
    send(8'h40, 1'b1, 1'b0);
    check("clr_err", 64'(err_flag), 64'd0);
    commit();
    do_tick();

    // Out-of-range index, then commit accepted together with a tick.
    send(8'h10, 1'b1, 1'b0);
    send(8'd10, 1'b0, 1'b0);
    check("idx_err", 64'(err_flag), 64'd1);
    send(8'h40, 1'b1, 1'b0);
    write_coeff(4, 64'hA5A5_5A5A_DEAD_BEEF);
    send(8'h20, 1'b1, 1'b1);
    pend_m = 1'b1;
    cyc();
    check("same_tick_pend", 64'(commit_pending), 64'd1);
    check("same_tick_ready", 64'(rx_ready), 64'd0);
    check("same_tick_noapply", hp_x2_coeff, active_m[4]);
    check("same_tick_nodone", 64'(done_cnt), 64'(exp_done));
    do_tick();

    // Discard restores the shadow from the active set.
    write_coeff(9, 64'hFFFF_FFFF_FFFF_FFFF);
    send(8'h30, 1'b1, 1'b0);
    shadow_m = active_m;
    commit();
    do_tick();
    check("lp_x2_zero", lp_x2_coeff, 64'd0);

    // A command byte arriving with frame_start restarts a write mid-data.
    send(8'h10, 1'b1, 1'b0);
    send(8'd5, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send(8'h77, 1'b0, 1'b0);
    write_coeff(6, 64'h1122_3344_5566_7788);
    commit();
    do_tick();

    // Tick without pending commit does nothing.
    do_tick();

    // Random writes, several slots per commit.
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 3; w++) begin
        s = int'($urandom_range(0, 9));
        d = {$urandom, $urandom};
        write_coeff(s, d);
      end
      commit();
      do_tick();
    end

    // Reset with commit pending and a tick in the same cycle.
    write_coeff(1, 64'h0BAD_F00D_0BAD_F00D);
    commit();
    sample_tick = 1'b1;
    do_reset();
    sample_tick = 1'b0;
    cyc();
    check_all("mid_reset");
    check("mid_rst_pend", 64'(commit_pending), 64'd0);
    check("mid_rst_ready", 64'(rx_ready), 64'd1);
    check("mid_rst_done", 64'(done_cnt), 64'(exp_done));
    commit();
    do_tick();

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coeff_update_ctrl.md
COEFF_UPDATE_CTRL -- requirements
Module: coeff_update_ctrl

Interface
REQ-001 Parameter NUM_COEFF, default 10, number of biquad coefficient slots (hp 0-4, lp 5-9).
REQ-002 Parameter COEFF_BYTES, default 8, bytes per 64-bit coefficient, MSB first.
REQ-003 clk_48  in  1  system clock; sole clock of the block.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 frame_start  in  1  one-cycle pulse, SPI CS falling edge already synchronised to clk_48.
REQ-006 rx_byte  in  8  received SPI byte.
REQ-007 rx_valid  in  1  rx_byte valid; transfer occurs when rx_valid && rx_ready.
REQ-008 rx_ready  out  1  byte accept.
REQ-009 sample_tick  in  1  one-cycle pulse at each audio sample boundary.
REQ-010 hp_y1_coeff, hp_y2_coeff, hp_x0_coeff, hp_x1_coeff, hp_x2_coeff  out  64 signed each  active high-pass coefficients, slots 0-4.
REQ-011 lp_y1_coeff, lp_y2_coeff, lp_x0_coeff, lp_x1_coeff, lp_x2_coeff  out  64 signed each  active low-pass coefficients, slots 5-9.
REQ-012 commit_pending  out  1  commit requested, not yet applied.
REQ-013 commit_done  out  1  one-cycle pulse when active set updated.
REQ-014 err_flag  out  1  sticky protocol error; cleared by reset or CLR_ERR command.

Function
REQ-015 Frame = command byte then payload; commands: 0x10 WRITE (idx byte + COEFF_BYTES data bytes), 0x20 COMMIT, 0x30 DISCARD, 0x40 CLR_ERR; no payload except WRITE.
REQ-016 FSM states IDLE, GET_IDX, GET_DATA, DROP; frame_start forces GET to IDLE from any state.
REQ-017 IDLE: 0x10 -> GET_IDX; 0x20/0x30/0x40 act and stay IDLE; other byte -> set err_flag, DROP.
REQ-018 GET_IDX: idx < NUM_COEFF -> latch idx, clear byte counter, GET_DATA; idx >= NUM_COEFF -> err_flag, DROP.
REQ-019 GET_DATA: shift each byte into a 64-bit assembly register; on byte COEFF_BYTES-1 write shadow[idx] and return to IDLE.
REQ-020 Shadow write is visible the cycle after the final data byte is accepted; a partial write never modifies shadow.
REQ-021 DROP: accept and discard all bytes until frame_start.
REQ-022 COMMIT sets commit_pending the cycle after acceptance; rx_ready = !commit_pending.
REQ-023 On the first sample_tick with commit_pending already high: all active <= shadow atomically at that edge, commit_pending clears, commit_done pulses the following cycle.
REQ-024 A sample_tick in the same cycle as COMMIT acceptance does not apply; the next tick does.
REQ-025 DISCARD copies active -> shadow for all slots in one cycle.
REQ-026 frame_start and accepted rx_valid in same cycle: abort old frame, treat byte as command byte of new frame.
REQ-027 frame_start mid-WRITE: assembly discarded, no err_flag, shadow unchanged.
REQ-028 commit_pending survives frame_start; only reset or a sample_tick clears it.
REQ-029 Active outputs change only per REQ-023; never combinationally from inputs.

Reset
REQ-030 On reset: FSM IDLE, counters 0, commit_pending 0, commit_done 0, err_flag 0, rx_ready 1.
REQ-031 On reset, active and shadow x0 slots (2, 7) = 64'h4000_0000_0000_0000 (1.0, Q2.62), all other slots 0.
REQ-032 Reset asserted mid-frame or with commit pending overrides all other activity in that cycle.

Structure
REQ-033 Package coeff_ctrl_pkg holds command-code enum, state enum, NUM_COEFF, COEFF_BYTES, slot index constants and reset coefficient constants.
REQ-034 Sub-module coeff_bank holds shadow and active arrays with write, commit and discard ports; FSM lives in coeff_update_ctrl.

Verification
REQ-035 Reset -> hp_x0_coeff = lp_x0_coeff = 64'h4000_0000_0000_0000, other outputs 0, rx_ready 1.
REQ-036 WRITE idx 3, bytes 01..08, COMMIT, sample_tick -> hp_x1_coeff = 64'h0102030405060708 after tick, commit_done one pulse.
REQ-037 WRITE idx 0 with four data bytes then frame_start, COMMIT, tick -> hp_y1_coeff stays 0, err_flag 0.
REQ-038 Command 0x55 then 9 bytes -> err_flag 1, shadow unchanged; 0x40 in new frame -> err_flag 0.
REQ-039 WRITE idx 10 -> err_flag 1; COMMIT accepted in same cycle as sample_tick -> apply only on next tick, rx_ready 0 meanwhile.
REQ-040 WRITE idx 9 = 64'hFFFF_FFFF_FFFF_FFFF, DISCARD, COMMIT, tick -> lp_x2_coeff remains 0.
